// File: rtl/clock_display_pkg.sv
// Shared mode encodings and default mask
// constants for the clock display blocks.
package clock_display_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL      = 2'd0,
    MODE_SET_HOURS   = 2'd1,
    MODE_SET_MINUTES = 2'd2,
    MODE_ALARM_RING  = 2'd3
  } mode_e;

  localparam int DEF_DIGITS = 6;
  localparam int DEF_BLINK_TICKS = 8;

  localparam logic [5:0] DEF_COLON_MASK = 6'b011000;
  localparam logic [5:0] DEF_SEP_MASK   = 6'b000010;
  localparam logic [5:0] DEF_HOUR_MASK  = 6'b110000;
  localparam logic [5:0] DEF_MIN_MASK   = 6'b001100;

endpackage

// File: rtl/blink_timer.sv
// Blink half-period counter and phase bit.
// Restart forces a fresh visible half-period.
module blink_timer #(
  parameter int BLINK_TICKS = 8
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_tick,
  input  logic i_restart,
  output logic o_phase
);

  localparam int CW = $clog2(BLINK_TICKS);
  localparam logic [CW-1:0] LAST = CW'(BLINK_TICKS - 1);

  logic [CW-1:0] cnt;

  // Count ticks; wrap and toggle phase at the last one
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt     <= '0;
      o_phase <= 1'b1;
    end else if (i_restart) begin
      cnt     <= '0;
      o_phase <= 1'b1;
    end else if (i_tick) begin
      if (cnt == LAST) begin
        cnt     <= '0;
        o_phase <= ~o_phase;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dp_blink_controller.sv
// Decimal-point and digit-blank driver for a
// six-digit clock display with mode blinking.
module dp_blink_controller
  import clock_display_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BLINK_TICKS = DEF_BLINK_TICKS,
  parameter logic [DIGITS-1:0] COLON_MASK = DEF_COLON_MASK,
  parameter logic [DIGITS-1:0] SEP_MASK = DEF_SEP_MASK,
  parameter logic [DIGITS-1:0] HOUR_MASK = DEF_HOUR_MASK,
  parameter logic [DIGITS-1:0] MIN_MASK = DEF_MIN_MASK,
  parameter int AMPM_IDX = 0,
  parameter int ALARM_IDX = DIGITS - 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_tick,
  input  logic [1:0]        i_mode,
  input  logic              i_display_en,
  input  logic [5:0]        i_seconds,
  input  logic              i_am_pm,
  input  logic              i_alarm_en,
  output logic [DIGITS-1:0] o_dp,
  output logic [DIGITS-1:0] o_blank
);

  mode_e mode_q;
  mode_e mode_d;
  logic restart;
  logic phase;
  logic phase_eff;
  logic [DIGITS-1:0] dp_d;
  logic [DIGITS-1:0] blank_d;
  logic sec_unused;

  assign sec_unused = ^i_seconds[5:1];
  assign mode_d = mode_e'(i_mode);
  assign restart = (mode_d != mode_q);
  assign phase_eff = restart | phase;

  blink_timer #(
    .BLINK_TICKS(BLINK_TICKS)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_tick   (i_tick),
    .i_restart(restart),
    .o_phase  (phase)
  );

  // Track the mode so a change restarts blinking
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) mode_q <= MODE_NORMAL;
    else            mode_q <= mode_d;
  end

  // Decode the next DP/blank pattern from mode
  always_comb begin
    dp_d    = '0;
    blank_d = '0;
    unique case (mode_d)
      MODE_NORMAL: begin
        dp_d = (COLON_MASK & {DIGITS{i_seconds[0]}})
             | SEP_MASK;
        dp_d[AMPM_IDX]  = i_am_pm;
        dp_d[ALARM_IDX] = i_alarm_en;
      end
      MODE_SET_HOURS: begin
        dp_d = COLON_MASK;
        dp_d[AMPM_IDX]  = i_am_pm;
        dp_d[ALARM_IDX] = i_alarm_en;
        if (!phase_eff) blank_d = HOUR_MASK;
      end
      MODE_SET_MINUTES: begin
        dp_d = COLON_MASK;
        dp_d[AMPM_IDX]  = i_am_pm;
        dp_d[ALARM_IDX] = i_alarm_en;
        if (!phase_eff) blank_d = MIN_MASK;
      end
      MODE_ALARM_RING: begin
        dp_d = {DIGITS{phase_eff}};
      end
      default: begin
        dp_d    = '0;
        blank_d = '0;
      end
    endcase
    if (!i_display_en) begin
      dp_d    = '0;
      blank_d = '1;
    end
  end

  // Register the outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dp    <= '0;
      o_blank <= '0;
    end else begin
      o_dp    <= dp_d;
      o_blank <= blank_d;
    end
  end

endmodule

// File: tb/tb_dp_blink_controller.sv
// Directed bench for dp_blink_controller.
// Inputs change on negedge, checks on negedge.
module tb_dp_blink_controller;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [1:0] mode;
  logic       en;
  logic [5:0] sec;
  logic       am_pm;
  logic       alarm_en;
  logic [5:0] dp;
  logic [5:0] blank;

  int checks = 0;
  int errors = 0;

  dp_blink_controller dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_tick      (tick),
    .i_mode      (mode),
    .i_display_en(en),
    .i_seconds   (sec),
    .i_am_pm     (am_pm),
    .i_alarm_en  (alarm_en),
    .o_dp        (dp),
    .o_blank     (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [5:0] got,
                     input logic [5:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b",
             tag, got, exp);
    end
  endtask

  // one tick edge, then one idle edge so the
  // outputs show the post-tick state
  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] exp_b;
    logic [5:0] exp_d;

    rst_n = 1'b0;
    tick = 1'b0;
    mode = 2'd0;
    en = 1'b1;
    sec = 6'd7;
    am_pm = 1'b1;
    alarm_en = 1'b0;

    idle();
    idle();
    chk("reset_dp", dp, 6'b000000);
    chk("reset_blank", blank, 6'b000000);

    rst_n = 1'b1;
    idle();
    chk("normal_s7_dp", dp, 6'b011011);
    chk("normal_s7_blank", blank, 6'b000000);
    sec = 6'd8;
    idle();
    chk("normal_s8_dp", dp, 6'b000011);
    alarm_en = 1'b1;
    am_pm = 1'b0;
    idle();
    chk("normal_alarm_dp", dp, 6'b100010);
    alarm_en = 1'b0;
    am_pm = 1'b1;

    mode = 2'd1;
    idle();
    chk("sethr_enter_dp", dp, 6'b011001);
    chk("sethr_enter_blank", blank, 6'b000000);
    for (int i = 1; i <= 16; i++) begin
      do_tick();
      exp_b = (i >= 8 && i < 16) ? 6'b110000 : 6'b000000;
      chk($sformatf("sethr_t%0d_blank", i), blank, exp_b);
      chk($sformatf("sethr_t%0d_dp", i), dp, 6'b011001);
    end

    for (int i = 1; i <= 8; i++) do_tick();
    chk("sethr_ph0_blank", blank, 6'b110000);

    mode = 2'd2;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("setmin_restart_blank", blank, 6'b000000);
    chk("setmin_restart_dp", dp, 6'b011001);
    idle();
    for (int i = 1; i <= 8; i++) begin
      do_tick();
      exp_b = (i == 8) ? 6'b001100 : 6'b000000;
      chk($sformatf("setmin_t%0d_blank", i), blank, exp_b);
    end

    en = 1'b0;
    idle();
    chk("dis_dp", dp, 6'b000000);
    chk("dis_blank", blank, 6'b111111);
    for (int i = 1; i <= 5; i++) begin
      do_tick();
      chk($sformatf("dis_t%0d_dp", i), dp, 6'b000000);
      chk($sformatf("dis_t%0d_blank", i), blank, 6'b111111);
    end
    en = 1'b1;
    idle();
    chk("reen_blank", blank, 6'b001100);
    chk("reen_dp", dp, 6'b011001);
    do_tick();
    do_tick();
    chk("reen_t7_blank", blank, 6'b001100);
    do_tick();
    chk("reen_t8_blank", blank, 6'b000000);

    mode = 2'd3;
    idle();
    chk("alarm_enter_dp", dp, 6'b111111);
    chk("alarm_enter_blank", blank, 6'b000000);
    for (int i = 1; i <= 24; i++) begin
      do_tick();
      exp_d = ((i / 8) % 2 == 0) ? 6'b111111 : 6'b000000;
      chk($sformatf("alarm_t%0d_dp", i), dp, exp_d);
      chk($sformatf("alarm_t%0d_blank", i), blank, 6'b000000);
    end

    for (int i = 1; i <= 11; i++) do_tick();
    chk("pre_rst_dp", dp, 6'b111111);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dp", dp, 6'b000000);
    chk("async_rst_blank", blank, 6'b000000);
    idle();
    idle();
    rst_n = 1'b1;
    idle();
    chk("post_rst_dp", dp, 6'b111111);
    for (int i = 1; i <= 8; i++) begin
      do_tick();
      exp_d = (i == 8) ? 6'b000000 : 6'b111111;
      chk($sformatf("post_rst_t%0d_dp", i), dp, exp_d);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_blink_controller.md
DP_BLINK_CONTROLLER -- requirements
Module: dp_blink_controller

Interface
REQ-001 Parameter DIGITS, default 6: number of display digits, each with one decimal point and one blank control.
REQ-002 Parameter BLINK_TICKS, default 8: i_tick pulses per blink half-period; legal range 2..256.
REQ-003 Parameter COLON_MASK, default 6'b011000: DP bits forming the hours/minutes colon.
REQ-004 Parameter SEP_MASK, default 6'b000010: DP bits forming the minutes/seconds separator.
REQ-005 Parameters HOUR_MASK, default 6'b110000, and MIN_MASK, default 6'b001100: digits blanked while setting hours or minutes.
REQ-006 Parameters AMPM_IDX, default 0, and ALARM_IDX, default DIGITS-1: indicator DP positions, disjoint from COLON_MASK and SEP_MASK.
REQ-007 The block SHALL run on one clock and use an asynchronous, active-low reset.
REQ-008 i_clk  input  1  system clock; all state updates on its rising edge.
REQ-009 i_reset_n  input  1  asynchronous reset, active low.
REQ-010 i_tick  input  1  single-cycle blink-rate strobe, synchronous to i_clk.
REQ-011 i_mode  input  2  display mode: NORMAL=0, SET_HOURS=1, SET_MINUTES=2, ALARM_RING=3.
REQ-012 i_display_en  input  1  display enable; 0 forces the display dark.
REQ-013 i_seconds  input  6  current seconds, 0..59 binary.
REQ-014 i_am_pm  input  1  PM indicator.
REQ-015 i_alarm_en  input  1  alarm-armed indicator.
REQ-016 o_dp  output  DIGITS  registered decimal-point drives, 1 = lit.
REQ-017 o_blank  output  DIGITS  registered digit blanking, 1 = digit dark.

Function
REQ-018 The block SHALL hold a tick counter cnt, a blink phase bit phase (1 = visible), and a registered mode mode_q.
REQ-019 On i_tick with cnt < BLINK_TICKS-1, cnt SHALL increment; at cnt = BLINK_TICKS-1, cnt SHALL wrap to 0 and phase SHALL toggle.
REQ-020 When i_mode differs from mode_q, the block SHALL load mode_q <= i_mode, cnt <= 0, and phase <= 1 in that cycle; this restart SHALL take priority over a coincident i_tick.
REQ-021 Outputs SHALL be registered, so o_dp and o_blank reflect inputs and state with exactly one cycle of latency.
REQ-022 NORMAL mode:
 - COLON_MASK bits = i_seconds[0].
 - SEP_MASK bits = 1.
 - Bit AMPM_IDX = i_am_pm; bit ALARM_IDX = i_alarm_en.
 - All other DP bits = 0.
 - o_blank = 0.
REQ-023 SET_HOURS mode:
 - COLON_MASK bits = 1; SEP_MASK bits = 0.
 - AMPM/ALARM bits as in NORMAL.
 - o_blank = HOUR_MASK when phase = 0, else 0.
REQ-024 SET_MINUTES mode SHALL match SET_HOURS, except that o_blank = MIN_MASK when phase = 0.
REQ-025 ALARM_RING mode SHALL drive every o_dp bit to phase and o_blank to 0.
REQ-026 i_display_en = 0 SHALL force o_dp to 0 and o_blank to all ones.
 - The blink counter and mode tracking SHALL continue running while the display is disabled.
REQ-027 Output decoding SHALL use the new mode value in the cycle a mode change is detected, with phase taken as 1.

Reset
REQ-028 While i_reset_n = 0, the block SHALL hold cnt = 0, phase = 1, mode_q = NORMAL, o_dp = 0, o_blank = 0.
REQ-029 A reset asserted mid-blink SHALL discard any partial count; after release the first phase toggle SHALL occur on the BLINK_TICKS-th i_tick.

Structure
REQ-030 The mode encodings and default mask constants SHALL live in the shared package clock_display_pkg.
REQ-031 The tick counter and phase logic SHALL be one sub-module, blink_timer, with ports i_clk, i_reset_n, i_tick, i_restart, o_phase.
 - Parameter: BLINK_TICKS.
 - Counter width: $clog2(BLINK_TICKS).

Verification
REQ-032 Reset with NORMAL mode, i_seconds=7, i_am_pm=1, i_alarm_en=0 -> one cycle later o_dp=6'b011011 and o_blank=0; with i_seconds=8 -> o_dp=6'b000011.
REQ-033 Switch to SET_HOURS and apply 8 ticks -> o_blank=0 for ticks 1..7 and 6'b110000 after tick 8; after tick 16, o_blank=0; o_dp colon=1 and separator=0 throughout.
REQ-034 In SET_HOURS with phase=0, switch to SET_MINUTES on the same cycle as an i_tick -> next cycle o_blank=0, cnt=0, and phase stays 1 until 8 further ticks, after which o_blank=6'b001100.
REQ-035 ALARM_RING with 24 ticks -> o_dp toggles between 6'b111111 and 6'b000000 at every 8th tick, and o_blank stays 0.
REQ-036 Deassert i_display_en in SET_MINUTES for 5 ticks, then reassert -> o_dp=0 and o_blank=6'b111111 while disabled; on reassertion, blinking resumes with the count continued, not restarted.
REQ-037 Assert i_reset_n=0 asynchronously mid-half-period, between clock edges -> outputs clear immediately; after release, the first toggle occurs exactly on the 8th tick.
